vga_ram_dp: RTL and testbench

Parametrised single-clock dual-port RAM for the VGA console's text/attribute buffer. It supports a configurable data width, byte-wide write strobes and read-valid handshaking. A built-in clear engine fills the whole array with a programmable value after reset or on request. Port A (the scan-out reader) gets write-to-read forwarding on same-address collisions. Port B is the bus-side read/write port.

---
 rtl/vga_ram_pkg.sv | 33 +++
 rtl/vga_ram_core.sv | 53 +++++
 rtl/vga_ram_dp.sv | 198 +++++++++++++++++++
 tb/tb_vga_ram_dp.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_ram_pkg.sv
// Shared definitions for the VGA text/attribute RAM: clear-FSM states,
// byte-lane width and the byte-strobe merge used by both the write path
// and the port A collision forwarding. Callers derive their data width
// as DW = BYTE_W * DATA_BYTES.
package vga_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_e;

    localparam int unsigned BYTE_W    = 8;
    // merge() works on the widest supported word; callers zero-extend and truncate.
    localparam int unsigned MAX_BYTES = 16;
    localparam int unsigned MAX_DW    = BYTE_W * MAX_BYTES;

    // Replace each byte of old_w whose strobe bit is set with the same byte of new_w.
    function automatic logic [MAX_DW-1:0] merge(
        input logic [MAX_DW-1:0]    old_w,
        input logic [MAX_DW-1:0]    new_w,
        input logic [MAX_BYTES-1:0] strobe
    );
        logic [MAX_DW-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(MAX_BYTES); i++) begin
            if (strobe[i]) begin
                res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_ram_core.sv
// Plain dual-port byte-strobe RAM kept free of control logic so it maps
// onto a block RAM. One write port, two registered read ports; a read and
// a write to the same address in one cycle return the old word.
// Ports:
//   clk, rst_n            clock, async active-low reset (read registers only)
//   we/waddr/wdata        byte-strobed write port
//   a_en/a_addr/a_rdata   read port A (rdata holds when a_en=0)
//   b_en/b_addr/b_rdata   read port B (rdata holds when b_en=0)
module vga_ram_core
    import vga_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_BYTES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_BYTES-1:0]        we,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [BYTE_W*DATA_BYTES-1:0] wdata,
    input  logic                         a_en,
    input  logic [ADDR_WIDTH-1:0]        a_addr,
    output logic [BYTE_W*DATA_BYTES-1:0] a_rdata,
    input  logic                         b_en,
    input  logic [ADDR_WIDTH-1:0]        b_addr,
    output logic [BYTE_W*DATA_BYTES-1:0] b_rdata
);

    localparam int unsigned DW    = BYTE_W * DATA_BYTES;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DW-1:0] mem [DEPTH];

    // Byte-lane writes; no reset on the array itself.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DATA_BYTES); i++) begin
            if (we[i]) begin
                mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Registered reads; non-blocking semantics give read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_en) a_rdata <= mem[a_addr];
            if (b_en) b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/vga_ram_dp.sv
// VGA console text/attribute buffer: single-clock dual-port RAM with a
// clear engine that fills the array with CLEAR_VALUE after reset or on
// clr_req, plus write-to-read forwarding to port A on same-address
// collisions with a port B write.
// Build option: define VGA_RAM_OUTREG_EN to add an output register stage
// on both read ports (2-cycle read latency, full throughput).
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clr_req        start a clear pass (taken only when idle)
//   busy           clear pass in progress; requests are dropped
//   a_req/a_addr   port A read request -> a_rdata/a_rvalid
//   b_req/b_addr/b_wstrobe/b_wdata   port B access (read-first) -> b_rdata/b_rvalid
module vga_ram_dp
    import vga_ram_pkg::*;
#(
    parameter int unsigned              ADDR_WIDTH  = 10,
    parameter int unsigned              DATA_BYTES  = 4,
    parameter logic [8*DATA_BYTES-1:0]  CLEAR_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_req,
    output logic                         busy,
    input  logic                         a_req,
    input  logic [ADDR_WIDTH-1:0]        a_addr,
    output logic [BYTE_W*DATA_BYTES-1:0] a_rdata,
    output logic                         a_rvalid,
    input  logic                         b_req,
    input  logic [ADDR_WIDTH-1:0]        b_addr,
    input  logic [DATA_BYTES-1:0]        b_wstrobe,
    input  logic [BYTE_W*DATA_BYTES-1:0] b_wdata,
    output logic [BYTE_W*DATA_BYTES-1:0] b_rdata,
    output logic                         b_rvalid
);

    localparam int unsigned DW = BYTE_W * DATA_BYTES;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

    clr_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                    busy_q, busy_d;
    logic                    a_rv1_q, a_rv1_d;
    logic                    b_rv1_q, b_rv1_d;
    logic [DATA_BYTES-1:0]   fwd_strb_q, fwd_strb_d;
    logic [DW-1:0]           fwd_data_q, fwd_data_d;

    logic                    a_acc_c, b_acc_c, b_wr_c, coll_c;
    logic [DATA_BYTES-1:0]   core_we_c;
    logic [ADDR_WIDTH-1:0]   core_waddr_c;
    logic [DW-1:0]           core_wdata_c;
    logic [DW-1:0]           core_a_rdata, core_b_rdata;
    logic [DW-1:0]           a_data1_c;

    // Request gating and collision detect.
    always_comb begin
        a_acc_c = a_req && (state_q == IDLE);
        b_acc_c = b_req && (state_q == IDLE);
        b_wr_c  = b_acc_c && (b_wstrobe != '0);
        coll_c  = a_acc_c && b_wr_c && (a_addr == b_addr);
    end

    // Clear FSM: one word per cycle from address 0 to the last address.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == PTR_LAST) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    // Read-valid and forwarding capture. Forwarding state only changes when
    // A accepts a read, so the merged port A data holds between reads.
    always_comb begin
        a_rv1_d    = a_acc_c;
        b_rv1_d    = b_acc_c;
        fwd_strb_d = fwd_strb_q;
        fwd_data_d = fwd_data_q;
        if (a_acc_c) begin
            fwd_strb_d = coll_c ? b_wstrobe : '0;
            fwd_data_d = b_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            ptr_q      <= '0;
            busy_q     <= 1'b1;
            a_rv1_q    <= 1'b0;
            b_rv1_q    <= 1'b0;
            fwd_strb_q <= '0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            a_rv1_q    <= a_rv1_d;
            b_rv1_q    <= b_rv1_d;
            fwd_strb_q <= fwd_strb_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // RAM write port is owned by the clear engine during a pass, else by port B.
    always_comb begin
        core_we_c    = '0;
        core_waddr_c = b_addr;
        core_wdata_c = b_wdata;
        if (state_q == CLEAR) begin
            core_we_c    = '1;
            core_waddr_c = ptr_q;
            core_wdata_c = CLEAR_VALUE;
        end else if (b_wr_c) begin
            core_we_c    = b_wstrobe;
        end
    end

    vga_ram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_BYTES (DATA_BYTES)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (core_we_c),
        .waddr   (core_waddr_c),
        .wdata   (core_wdata_c),
        .a_en    (a_acc_c),
        .a_addr  (a_addr),
        .a_rdata (core_a_rdata),
        .b_en    (b_acc_c),
        .b_addr  (b_addr),
        .b_rdata (core_b_rdata)
    );

    // Port A sees the old word with B's colliding bytes overlaid.
    always_comb begin
        a_data1_c = DW'(merge(MAX_DW'(core_a_rdata), MAX_DW'(fwd_data_q),
                              MAX_BYTES'(fwd_strb_q)));
    end

    assign busy = busy_q;

`ifdef VGA_RAM_OUTREG_EN
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          a_rvalid_q, b_rvalid_q;

    // Extra output stage; data only advances with a completing read.
    always_comb begin
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        if (a_rv1_q) a_rdata_d = a_data1_c;
        if (b_rv1_q) b_rdata_d = core_b_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            a_rvalid_q <= a_rv1_q;
            b_rvalid_q <= b_rv1_q;
        end
    end

    assign a_rdata  = a_rdata_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rdata  = b_rdata_q;
    assign b_rvalid = b_rvalid_q;
`else
    assign a_rdata  = a_data1_c;
    assign a_rvalid = a_rv1_q;
    assign b_rdata  = core_b_rdata;
    assign b_rvalid = b_rv1_q;
`endif

endmodule

// File: tb/tb_vga_ram_dp.sv
// Scoreboard bench for vga_ram_dp (ADDR_WIDTH=4, 32-bit words). A stepping
// task drives one request set per cycle and predicts results from a word
// array model; a negedge monitor pops and compares when rvalid is seen.
module tb_vga_ram_dp;

    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] CV    = 32'hA5A5_5A5A;
`ifdef VGA_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr_req = 1'b0;
    logic          busy;
    logic          a_req = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [31:0]   a_rdata;
    logic          a_rvalid;
    logic          b_req = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [3:0]    b_wstrobe = '0;
    logic [31:0]   b_wdata = '0;
    logic [31:0]   b_rdata;
    logic          b_rvalid;

    vga_ram_dp #(
        .ADDR_WIDTH  (AW),
        .DATA_BYTES  (4),
        .CLEAR_VALUE (CV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .busy      (busy),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_rdata   (a_rdata),
        .a_rvalid  (a_rvalid),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_wstrobe (b_wstrobe),
        .b_wdata   (b_wdata),
        .b_rdata   (b_rdata),
        .b_rvalid  (b_rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] mem_m [DEPTH];
    logic        busy_m;
    int          cnt_m;

    // Byte-wise overlay of strobed bytes of nw onto old.
    function automatic logic [31:0] overlay(input logic [31:0] old,
                                            input logic [31:0] nw,
                                            input logic [3:0]  strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fill_model();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = CV;
    endtask

    // One cycle of stimulus; model predicts what the next edge does.
    task automatic step(input logic ar, input logic [AW-1:0] aa,
                        input logic br, input logic [AW-1:0] ba,
                        input logic [3:0] bs, input logic [31:0] bd,
                        input logic cr);
        exp_t e;
        a_req = ar; a_addr = aa; b_req = br; b_addr = ba;
        b_wstrobe = bs; b_wdata = bd; clr_req = cr;
        if (!busy_m) begin
            if (ar) begin
                e.data = (br && bs != 4'b0 && ba == aa) ? overlay(mem_m[aa], bd, bs) : mem_m[aa];
                e.due  = cyc + LAT;
                qa.push_back(e);
            end
            if (br) begin
                e.data = mem_m[ba];
                e.due  = cyc + LAT;
                qb.push_back(e);
                if (bs != 4'b0) mem_m[ba] = overlay(mem_m[ba], bd, bs);
            end
            if (cr) begin
                busy_m = 1'b1;
                cnt_m  = DEPTH;
                fill_model();
            end
        end else begin
            cnt_m--;
            if (cnt_m == 0) busy_m = 1'b0;
        end
        @(posedge clk);
        #1;
        check("busy", {31'b0, busy}, {31'b0, busy_m});
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, '0, 4'b0, 32'b0, 1'b0);
    endtask

    task automatic rand_step(input logic allow_clr);
        logic [AW-1:0] aa, ba;
        logic [3:0]    bs;
        aa = AW'($urandom_range(0, DEPTH - 1));
        ba = ($urandom_range(0, 2) == 0) ? aa : AW'($urandom_range(0, DEPTH - 1));
        bs = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
        step(1'($urandom_range(0, 1)), aa, 1'($urandom_range(0, 1)), ba, bs,
             $urandom, allow_clr && ($urandom_range(0, 99) == 0));
    endtask

    // Called just after a rising edge; reset is asserted asynchronously.
    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        a_req = 1'b0; b_req = 1'b0; clr_req = 1'b0; b_wstrobe = '0;
        qa.delete();
        qb.delete();
        busy_m = 1'b1;
        cnt_m  = DEPTH;
        fill_model();
        #1;
        check("rst_a_rvalid", {31'b0, a_rvalid}, 32'b0);
        check("rst_b_rvalid", {31'b0, b_rvalid}, 32'b0);
        repeat (hold) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_a_rdata", a_rdata, 32'b0);
        check("rst_b_rdata", b_rdata, 32'b0);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (a_rvalid) begin
            n_cmp++;
            if (!rst_n || qa.size() == 0) begin
                n_bad++;
                $display("FAIL a_rvalid_unexpected: got 1 expected 0 (t=%0t)", $time);
            end else begin
                e = qa.pop_front();
                check("a_rdata", a_rdata, e.data);
                check("a_latency", 32'(cyc), 32'(e.due));
            end
        end else if (qa.size() > 0 && qa[0].due <= cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL a_rvalid_missing: got 0 expected 1 (t=%0t)", $time);
            void'(qa.pop_front());
        end
        if (b_rvalid) begin
            n_cmp++;
            if (!rst_n || qb.size() == 0) begin
                n_bad++;
                $display("FAIL b_rvalid_unexpected: got 1 expected 0 (t=%0t)", $time);
            end else begin
                e = qb.pop_front();
                check("b_rdata", b_rdata, e.data);
                check("b_latency", 32'(cyc), 32'(e.due));
            end
        end else if (qb.size() > 0 && qb[0].due <= cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL b_rvalid_missing: got 0 expected 1 (t=%0t)", $time);
            void'(qb.pop_front());
        end
    end

    initial begin
        #1;
        do_reset(2);
        // Reset pass, then read every word.
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), 1'b0, '0, 4'b0, 32'b0, 1'b0);
        idle(2);

        // Byte-strobe writes and read back.
        step(1'b0, '0, 1'b1, 4'd5, 4'b1111, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, '0, 1'b1, 4'd5, 4'b0010, 32'h0000_1100, 1'b0);
        step(1'b0, '0, 1'b1, 4'd5, 4'b0000, 32'h0, 1'b0);

        // Collision with forwarding, then read back.
        step(1'b0, '0, 1'b1, 4'd7, 4'b1111, 32'h1122_3344, 1'b0);
        step(1'b1, 4'd7, 1'b1, 4'd7, 4'b0101, 32'hAABB_CCDD, 1'b0);
        step(1'b1, 4'd7, 1'b1, 4'd7, 4'b0000, 32'h0, 1'b0);
        idle(2);

        // Clear after writes; requests during the pass are dropped; a second
        // clr_req mid-pass must not extend it.
        step(1'b0, '0, 1'b1, 4'd3, 4'b1111, 32'h1234_5678, 1'b0);
        step(1'b0, '0, 1'b0, '0, 4'b0, 32'b0, 1'b1);
        step(1'b1, 4'd3, 1'b1, 4'd3, 4'b1111, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 4'd9, 1'b1, 4'd9, 4'b0011, 32'h0BAD_0BAD, 1'b0);
        idle(4);
        step(1'b0, '0, 1'b0, '0, 4'b0, 32'b0, 1'b1);
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), 1'b1, AW'(DEPTH - 1 - i), 4'b0, 32'b0, 1'b0);

        // Random traffic with occasional clears.
        for (int i = 0; i < 600; i++) rand_step(1'b1);
        idle(DEPTH + 2);

        // Reset at pass cycle 8 with requests in flight.
        step(1'b0, '0, 1'b0, '0, 4'b0, 32'b0, 1'b1);
        for (int i = 0; i < 7; i++) rand_step(1'b0);
        do_reset(1);
        for (int i = 0; i < DEPTH; i++) rand_step(1'b0);
        for (int i = 0; i < 40; i++) rand_step(1'b0);

        // Reset while reads are outstanding.
        step(1'b1, 4'd2, 1'b1, 4'd4, 4'b0, 32'b0, 1'b0);
        do_reset(1);
        idle(DEPTH + 2);
        for (int i = 0; i < 100; i++) rand_step(1'b1);

        idle(DEPTH + 4);
        check("a_queue_drained", 32'(qa.size()), 32'd0);
        check("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL timeout: got no end of test expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
